fpu_issue: RTL
==============

// Module: fpu_issue
// PURPOSE
// Upstream issue/sequencer for the fpu result-mux block. Accepts one FP operation at a time from the
// core execute stage (valid/ready), registers operands, drives the one-hot fpu_in_valid bus for the
// selected operator, waits for fpu_out_valid, captures fpu_out, and returns the result with its
// destination tag to writeback. Exactly one operation in flight; the core stalls on req_ready=0.
// PARAMETERS
// TAG_W        6    width of destination register tag carried alongside the op
// TIMEOUT_CYC  64   watchdog limit in cycles spent in WAIT (used only with FPU_WDT_EN)
// PORTS
// clk            in   1      clock, all state on rising edge
// rst            in   1      reset, asynchronous, active-high
// req_valid      in   1      core presents an FP op
// req_ready      out  1      issue can accept (high only in IDLE)
// req_op         in   4      1 fadd,2 fsub,3 fmul,4 fdiv,5 fsqrt,6 fabs,7 fcmp,8 fftoi,9 fitof
// req_a/req_b    in   32     operands (b ignored by unary ops)
// req_cmp_op     in   8      fcmp predicate
// req_tag        in   TAG_W  destination register tag
// fpu_in_valid   out  10     one-hot operator strobe, bit[req_op]; bit0 never set
// fpu_in_ready   in   1      selected operator accepted its inputs this cycle
// fpu_a/fpu_b    out  32     registered operands to operators
// fpu_cmp_op     out  8      registered fcmp predicate
// fpu_out        in   32     muxed result
// fpu_out_valid  in   1      result strobe (1-cycle)
// rsp_valid      out  1      result available to writeback
// rsp_ready      in   1      writeback consumes result
// rsp_data       out  32     captured result
// rsp_tag        out  TAG_W  tag of the completed op
// rsp_err        out  1      1 = illegal op (or watchdog expiry)
// BEHAVIOUR
// - Reset: state=IDLE; fpu_in_valid=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_tag=0,
//   fpu_a/fpu_b=0, fpu_cmp_op=0; req_ready=1 one cycle after rst deasserts. Reset mid-op aborts it;
//   a late fpu_out_valid after reset is ignored (state IDLE).
// - FSM IDLE->ISSUE->WAIT->DONE->IDLE. req_ready = (state==IDLE), combinational.
// - IDLE: on req_valid, latch a, b, cmp_op, op, tag. op in 1..9 -> ISSUE; op 0 or 10..15 -> DONE
//   directly with rsp_data=0, rsp_err=1 (no fpu_in_valid pulse).
// - ISSUE: fpu_in_valid[op]=1 (registered, asserted from first ISSUE cycle); held until cycle where
//   fpu_in_ready=1, then deasserted next cycle and state->WAIT. Minimum: accept at cycle N,
//   fpu_in_valid high N+1, WAIT at N+2 when ready on first strobe.
// - WAIT: on fpu_out_valid capture rsp_data=fpu_out, rsp_err=0, ->DONE. fpu_out_valid seen in ISSUE
//   same cycle as fpu_in_ready (0-latency operator) is also captured, going ISSUE->DONE.
//   fpu_out_valid in IDLE/DONE is ignored.
// - DONE: rsp_valid=1 with stable data/tag/err until rsp_ready; on handshake -> IDLE, rsp_valid=0.
//   No bypass: a new request is accepted no earlier than the cycle after the rsp handshake.
// - fcmp result (8-bit) arrives zero-extended on fpu_out; captured as-is.
// CONFIGURATION
// FPU_WDT_EN defined: counter (clog2(TIMEOUT_CYC+1) bits) clears entering WAIT, increments each WAIT
//   cycle; reaching TIMEOUT_CYC without fpu_out_valid -> DONE, rsp_data=0, rsp_err=1. fpu_out_valid
//   on the expiry cycle wins (normal completion).
// FPU_WDT_EN undefined: no counter; WAIT is held indefinitely until fpu_out_valid.
// TESTING
// 1 reset: rst pulse mid-WAIT -> next cycle state IDLE, all outputs 0, req_ready=1, late valid ignored.
// 2 fadd op=1 a=3F800000 b=40000000, ready immediate, fpu_out=40400000 after 4 cyc -> fpu_in_valid=
//   10'b0000000010 for 1 cyc, rsp_data=40400000, rsp_err=0, tag echoed.
// 3 fcmp op=7 cmp_op=8'h24, fpu_in_ready low 3 cyc -> fpu_in_valid[7] held 4 cyc, fpu_cmp_op=24.
// 4 op=0 and op=12 -> no fpu_in_valid pulse, rsp_valid next cycle, rsp_data=0, rsp_err=1.
// 5 rsp_ready low 5 cyc with req_valid high -> rsp stable, req_ready=0, no second issue.
// 6 FPU_WDT_EN, TIMEOUT_CYC=8, no fpu_out_valid -> rsp_err=1 after 8 WAIT cycles; without macro stays WAIT.

Source files
------------

// File: rtl/fpu_issue.sv
// fpu_issue: single-op issue/sequencer in front of the fpu result-mux block.
// Accepts one FP op from execute, strobes the selected operator one-hot, waits
// for its result and hands data and tag back to writeback. Only one op is in
// flight at a time.
// Optional macro FPU_WDT_EN: adds a WAIT-state watchdog that returns an error
// response after TIMEOUT_CYC cycles without fpu_out_valid.
module fpu_issue #(
    parameter int TAG_W       = 6,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [7:0]       req_cmp_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [9:0]       fpu_in_valid,
    input  logic             fpu_in_ready,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [7:0]       fpu_cmp_op,
    input  logic [31:0]      fpu_out,
    input  logic             fpu_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state;

`ifdef FPU_WDT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wdt_cnt;
`else
    // Timeout only matters when the watchdog is built in.
    logic [31:0] wdt_unused;
    assign wdt_unused = 32'(TIMEOUT_CYC);
`endif

    // New work is only taken while nothing is in flight.
    assign req_ready = (state == IDLE);

    // Sequencer: accept, strobe operator until accepted, wait for result, hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fpu_in_valid <= '0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            fpu_cmp_op   <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_tag      <= '0;
            rsp_err      <= 1'b0;
`ifdef FPU_WDT_EN
            wdt_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        fpu_a      <= req_a;
                        fpu_b      <= req_b;
                        fpu_cmp_op <= req_cmp_op;
                        rsp_tag    <= req_tag;
                        if (req_op >= 4'd1 && req_op <= 4'd9) begin
                            fpu_in_valid <= 10'd1 << req_op;
                            state        <= ISSUE;
                        end else begin
                            // Illegal opcode: never touches an operator.
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (fpu_in_ready) begin
                        fpu_in_valid <= '0;
                        if (fpu_out_valid) begin
                            // Zero-latency operator answered in the accept cycle.
                            rsp_data  <= fpu_out;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= WAIT;
`ifdef FPU_WDT_EN
                            wdt_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (fpu_out_valid) begin
                        rsp_data  <= fpu_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
`ifdef FPU_WDT_EN
                    else if (wdt_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wdt_cnt <= wdt_cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
